// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// mem_port_arbiter
// Shares one external memory port between instruction fetch and the data stage.
// Only one transaction is in flight at a time, and data has priority over fetch.
// A watchdog turns a non-responding memory into an abort response.
// Each access passes through a one-cycle response state, so the requester
// advances before the next arbitration.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IReq,
    input  logic [31:0] IAdr,
    input  logic        IFlush,
    input  logic        DReq,
    input  logic [31:0] DAdr,
    input  logic        DWE,
    input  logic [31:0] DWD,
    input  logic [3:0]  DBE,
    input  logic        MemAck,
    input  logic [31:0] MemRD,
    output logic        MemReq,
    output logic [31:0] MemAdr,
    output logic        MemWE,
    output logic [31:0] MemWD,
    output logic [3:0]  MemBE,
    output logic [31:0] InstrRd,
    output logic        IValid,
    output logic        IAbort,
    output logic [31:0] DataRd,
    output logic        DValid,
    output logic        DAbort,
    output logic        IStall,
    output logic        DStall
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_IACC = 2'd1;
    localparam logic [1:0] S_DACC = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    // Last watchdog count before the access is declared dead.
    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 32'd1);

    logic [1:0]  state_r;
    logic [1:0]  state_nxt_s;
    logic [15:0] wdog_r;
    logic        drop_r;
    logic        in_acc_s;
    logic        timeout_s;
    logic        done_s;
    logic        drop_now_s;
    logic        take_d_s;
    logic        take_i_s;

    // Decode of the current access: acceptance, completion, timeout and fetch drop.
    always_comb begin
        in_acc_s   = (state_r == S_IACC) || (state_r == S_DACC);
        take_d_s   = (state_r == S_IDLE) && DReq;
        take_i_s   = (state_r == S_IDLE) && !DReq && IReq && !IFlush;
        timeout_s  = in_acc_s && !MemAck && (wdog_r == WDOG_LAST);
        done_s     = in_acc_s && (MemAck || timeout_s);
        drop_now_s = (state_r == S_IACC) && (drop_r || IFlush);
    end

    // Next-state selection for the access sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (take_d_s) begin
                    state_nxt_s = S_DACC;
                end else if (take_i_s) begin
                    state_nxt_s = S_IACC;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_IACC: begin
                if (done_s) begin
                    state_nxt_s = S_RESP;
                end else begin
                    state_nxt_s = S_IACC;
                end
            end
            S_DACC: begin
                if (done_s) begin
                    state_nxt_s = S_RESP;
                end else begin
                    state_nxt_s = S_DACC;
                end
            end
            S_RESP:  state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Watchdog: zero outside an access, counts every un-acknowledged access cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog_r <= 16'd0;
        end else if (!in_acc_s) begin
            wdog_r <= 16'd0;
        end else if (!MemAck) begin
            wdog_r <= wdog_r + 16'd1;
        end else begin
            wdog_r <= wdog_r;
        end
    end

    // Drop bit: remembers a redirect seen while a fetch is in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_r <= 1'b0;
        end else if (state_r == S_IDLE) begin
            drop_r <= 1'b0;
        end else if (drop_now_s) begin
            drop_r <= 1'b1;
        end else begin
            drop_r <= drop_r;
        end
    end

    // Memory request and its attributes: loaded on acceptance, frozen until the exit edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            MemReq <= 1'b0;
            MemAdr <= 32'd0;
            MemWE  <= 1'b0;
            MemWD  <= 32'd0;
            MemBE  <= 4'd0;
        end else if (take_d_s) begin
            MemReq <= 1'b1;
            MemAdr <= DAdr;
            MemWE  <= DWE;
            MemWD  <= DWD;
            MemBE  <= DWE ? DBE : 4'hF;
        end else if (take_i_s) begin
            MemReq <= 1'b1;
            MemAdr <= IAdr;
            MemWE  <= 1'b0;
            MemBE  <= 4'hF;
        end else if (done_s) begin
            MemReq <= 1'b0;
        end else begin
            MemReq <= MemReq;
        end
    end

    // Response pulses and read-data capture; aborted accesses return zero data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            InstrRd <= 32'd0;
            IValid  <= 1'b0;
            IAbort  <= 1'b0;
            DataRd  <= 32'd0;
            DValid  <= 1'b0;
            DAbort  <= 1'b0;
        end else begin
            IValid <= 1'b0;
            IAbort <= 1'b0;
            DValid <= 1'b0;
            DAbort <= 1'b0;
            if (done_s && (state_r == S_DACC)) begin
                DValid <= 1'b1;
                DAbort <= timeout_s;
                DataRd <= timeout_s ? 32'd0 : MemRD;
            end else if (done_s && (state_r == S_IACC) && !drop_now_s) begin
                IValid  <= 1'b1;
                IAbort  <= timeout_s;
                InstrRd <= timeout_s ? 32'd0 : MemRD;
            end else begin
                DataRd  <= DataRd;
                InstrRd <= InstrRd;
            end
        end
    end

    // Stalls depend only on requests and registered valids, never on MemAck.
    assign IStall = IReq & ~IValid;
    assign DStall = DReq & ~DValid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for mem_port_arbiter: directed vectors, hand sequences and
// randomized accesses checked against a per-transaction reference model.
module tb_mem_port_arbiter;

    localparam int TA = 16;
    localparam int TB = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        IReq, IFlush, DReq, DWE, MemAck;
    logic [31:0] IAdr, DAdr, DWD, MemRD;
    logic [3:0]  DBE;

    logic        MemReq, MemWE, IValid, IAbort, DValid, DAbort, IStall, DStall;
    logic [31:0] MemAdr, MemWD, InstrRd, DataRd;
    logic [3:0]  MemBE;

    logic        b_MemReq, b_MemWE, b_IValid, b_IAbort, b_DValid, b_DAbort, b_IStall, b_DStall;
    logic [31:0] b_MemAdr, b_MemWD, b_InstrRd, b_DataRd;
    logic [3:0]  b_MemBE;

    int n_cmp = 0;
    int n_bad = 0;

    mem_port_arbiter #(.TIMEOUT(TA)) dut (
        .clk(clk), .reset(reset),
        .IReq(IReq), .IAdr(IAdr), .IFlush(IFlush),
        .DReq(DReq), .DAdr(DAdr), .DWE(DWE), .DWD(DWD), .DBE(DBE),
        .MemAck(MemAck), .MemRD(MemRD),
        .MemReq(MemReq), .MemAdr(MemAdr), .MemWE(MemWE), .MemWD(MemWD), .MemBE(MemBE),
        .InstrRd(InstrRd), .IValid(IValid), .IAbort(IAbort),
        .DataRd(DataRd), .DValid(DValid), .DAbort(DAbort),
        .IStall(IStall), .DStall(DStall)
    );

    mem_port_arbiter #(.TIMEOUT(TB)) dut_b (
        .clk(clk), .reset(reset),
        .IReq(IReq), .IAdr(IAdr), .IFlush(IFlush),
        .DReq(DReq), .DAdr(DAdr), .DWE(DWE), .DWD(DWD), .DBE(DBE),
        .MemAck(MemAck), .MemRD(MemRD),
        .MemReq(b_MemReq), .MemAdr(b_MemAdr), .MemWE(b_MemWE), .MemWD(b_MemWD), .MemBE(b_MemBE),
        .InstrRd(b_InstrRd), .IValid(b_IValid), .IAbort(b_IAbort),
        .DataRd(b_DataRd), .DValid(b_DValid), .DAbort(b_DAbort),
        .IStall(b_IStall), .DStall(b_DStall)
    );

    // Free-running clock, 10 ns period.
    always #5 clk = ~clk;

    // Vector fields (positional order): d, i, dwe, wiggle, dadr, dwd, dbe, iadr,
    // rd_d, rd_i, lat_d, lat_i, flush_i, exp_be_d, exp_cyc_d, exp_abort_d,
    // exp_cyc_i, exp_abort_i, exp_ivalid.  lat = access cycle carrying MemAck,
    // flush_i = access cycle carrying IFlush (0 = none).
    typedef struct {
        bit          d, i, dwe, wiggle;
        logic [31:0] dadr, dwd;
        logic [3:0]  dbe;
        logic [31:0] iadr, rd_d, rd_i;
        int          lat_d, lat_i, flush_i;
        logic [3:0]  exp_be_d;
        int          exp_cyc_d;
        bit          exp_abort_d;
        int          exp_cyc_i;
        bit          exp_abort_i, exp_ivalid;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Starts at an IDLE negedge with the request driven; ends at the RESP negedge.
    task automatic serve(input bit is_d, input logic [31:0] adr, input bit we,
                         input logic [3:0] be, input logic [31:0] wd, input logic [31:0] rd,
                         input int lat, input int flush_c, input bit wiggle,
                         input int exp_cyc, input bit exp_abort, input bit exp_valid);
        int c;
        logic [31:0] exp_data;
        c = 0;
        step();
        while (MemReq === 1'b1 && c < 200) begin
            c++;
            chk("acc_adr", MemAdr, adr);
            chk("acc_we", MemWE, we);
            chk("acc_be", MemBE, be);
            if (we) chk("acc_wd", MemWD, wd);
            chk("acc_stall", is_d ? DStall : IStall, 1);
            MemAck = (c == lat);
            MemRD  = (c == lat) ? rd : $urandom;
            IFlush = (!is_d && c == flush_c);
            if (wiggle) begin
                DWD  = $urandom;
                IAdr = $urandom;
            end
            step();
        end
        MemAck = 1'b0;
        IFlush = 1'b0;
        chk("req_cycles", c, exp_cyc);
        exp_data = exp_abort ? 32'd0 : rd;
        if (is_d) begin
            chk("resp_dvalid", DValid, 1);
            chk("resp_dabort", DAbort, exp_abort);
            chk("resp_dataRd", DataRd, exp_data);
            chk("resp_ivalid_quiet", IValid, 0);
            chk("resp_dstall", DStall, 0);
        end else begin
            chk("resp_ivalid", IValid, exp_valid);
            chk("resp_iabort", IAbort, exp_abort && exp_valid);
            if (exp_valid) chk("resp_instrRd", InstrRd, exp_data);
            chk("resp_dvalid_quiet", DValid, 0);
            chk("resp_istall", IStall, !exp_valid);
        end
    endtask

    task automatic run_vec(input vec_t v);
        chk("idle_req", MemReq, 0);
        DReq = v.d; DAdr = v.dadr; DWE = v.dwe; DWD = v.dwd; DBE = v.dbe;
        IReq = v.i; IAdr = v.iadr;
        if (v.d) begin
            serve(1'b1, v.dadr, v.dwe, v.exp_be_d, v.dwd, v.rd_d, v.lat_d, 0, v.wiggle,
                  v.exp_cyc_d, v.exp_abort_d, 1'b1);
            DReq = 1'b0;
            step();
            if (v.i) begin
                chk("gap_idle_req", MemReq, 0);
                chk("gap_istall", IStall, 1);
            end
        end
        if (v.i) begin
            serve(1'b0, v.iadr, 1'b0, 4'hF, 32'd0, v.rd_i, v.lat_i, v.flush_i, 1'b0,
                  v.exp_cyc_i, v.exp_abort_i, v.exp_ivalid);
            IReq = 1'b0;
            step();
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
    endtask

    vec_t tbl[9];

    // Main stimulus sequence.
    initial begin
        int c;
        vec_t v;
        reset = 1'b1;
        IReq = 1'b0; IFlush = 1'b0; DReq = 1'b0; DWE = 1'b0; MemAck = 1'b0;
        IAdr = 32'd0; DAdr = 32'd0; DWD = 32'd0; MemRD = 32'd0; DBE = 4'd0;

        tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h100,
                   32'h0, 32'hE3A00001, 0, 1, 0, 4'h0, 0, 1'b0, 1, 1'b0, 1'b1};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h2000, 32'hAAAAAAAA, 4'b0011, 32'h300,
                   32'h0, 32'h12345678, 2, 2, 0, 4'b0011, 2, 1'b0, 2, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h104,
                   32'h0, 32'hDEADBEEF, 0, 3, 2, 4'h0, 0, 1'b0, 3, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h200,
                   32'h0, 32'hCAFEF00D, 0, 1, 0, 4'h0, 0, 1'b0, 1, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h40, 32'h11223344, 4'hC, 32'h0,
                   32'h0, 32'h0, 5, 0, 0, 4'hC, 5, 1'b0, 0, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h80, 32'h0, 4'b0101, 32'h0,
                   32'h55AA55AA, 32'h0, 3, 0, 0, 4'hF, 3, 1'b0, 0, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h500,
                   32'h0, 32'h77777777, 0, 20, 0, 4'h0, 0, 1'b0, 16, 1'b1, 1'b1};
        tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h900, 32'h0, 4'h0, 32'h0,
                   32'h66666666, 32'h0, 30, 0, 0, 4'hF, 16, 1'b1, 0, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h600,
                   32'h0, 32'h13579BDF, 0, 2, 2, 4'h0, 0, 1'b0, 2, 1'b0, 1'b0};

        // Reset state.
        #2;
        chk("rst_memreq", MemReq, 0);
        chk("rst_memadr", MemAdr, 0);
        chk("rst_membe", MemBE, 0);
        chk("rst_ivalid", IValid, 0);
        chk("rst_dvalid", DValid, 0);
        chk("rst_instrRd", InstrRd, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        step();

        // Directed vectors.
        foreach (tbl[k]) run_vec(tbl[k]);

        // Flush held in IDLE blocks fetch acceptance; ack in IDLE is ignored.
        IReq = 1'b1; IFlush = 1'b1; IAdr = 32'h700; MemAck = 1'b1;
        step();
        chk("flush_idle_req", MemReq, 0);
        step();
        chk("flush_idle_req2", MemReq, 0);
        chk("flush_idle_istall", IStall, 1);
        chk("idle_ack_ivalid", IValid, 0);
        chk("idle_ack_dvalid", DValid, 0);
        IReq = 1'b0; IFlush = 1'b0; MemAck = 1'b0;
        step();

        // Reset in the middle of a data access.
        DReq = 1'b1; DWE = 1'b1; DAdr = 32'h3000; DWD = 32'h5A5A5A5A; DBE = 4'h6;
        step();
        step();
        chk("mid_memreq_before", MemReq, 1);
        reset = 1'b1;
        #1;
        chk("arst_memreq", MemReq, 0);
        chk("arst_memadr", MemAdr, 0);
        chk("arst_memwe", MemWE, 0);
        chk("arst_memwd", MemWD, 0);
        chk("arst_membe", MemBE, 0);
        chk("arst_dataRd", DataRd, 0);
        chk("arst_instrRd", InstrRd, 0);
        chk("arst_valids", {IValid, IAbort, DValid, DAbort}, 0);
        DReq = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        MemAck = 1'b1;
        step();
        chk("spur_dvalid", DValid, 0);
        MemAck = 1'b0;
        step();
        chk("spur_dvalid2", DValid, 0);
        chk("spur_memreq", MemReq, 0);
        run_vec(tbl[3]);

        // Timeout on the short-watchdog instance.
        pulse_reset();
        DReq = 1'b1; DWE = 1'b0; DAdr = 32'h4000; MemAck = 1'b0;
        c = 0;
        step();
        while (b_MemReq === 1'b1 && c < 50) begin
            c++;
            step();
        end
        chk("to_req_cycles", c, TB);
        chk("to_dvalid", b_DValid, 1);
        chk("to_dabort", b_DAbort, 1);
        chk("to_dataRd", b_DataRd, 0);
        DReq = 1'b0;
        step();
        chk("to_idle_req", b_MemReq, 0);
        chk("to_idle_dvalid", b_DValid, 0);
        pulse_reset();

        // Randomized accesses against the transaction-level model.
        for (int n = 0; n < 40; n++) begin
            v.d = 1'($urandom_range(0, 1));
            v.i = 1'($urandom_range(0, 1));
            if (!v.d && !v.i) v.i = 1'b1;
            v.dwe = 1'($urandom_range(0, 1));
            v.wiggle = 1'b0;
            v.dadr = $urandom; v.dwd = $urandom; v.dbe = 4'($urandom);
            v.iadr = $urandom; v.rd_d = $urandom; v.rd_i = $urandom;
            v.lat_d = ($urandom_range(0, 7) == 0) ? 17 + $urandom_range(0, 3) : $urandom_range(1, 5);
            v.lat_i = ($urandom_range(0, 7) == 0) ? 17 + $urandom_range(0, 3) : $urandom_range(1, 5);
            v.exp_be_d    = v.dwe ? v.dbe : 4'hF;
            v.exp_cyc_d   = (v.lat_d > TA) ? TA : v.lat_d;
            v.exp_abort_d = (v.lat_d > TA);
            v.exp_cyc_i   = (v.lat_i > TA) ? TA : v.lat_i;
            v.exp_abort_i = (v.lat_i > TA);
            v.flush_i = ($urandom_range(0, 3) == 0) ? $urandom_range(1, v.exp_cyc_i) : 0;
            v.exp_ivalid  = (v.flush_i == 0);
            run_vec(v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL time_limit: got expired expected finish");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single external memory port between the fetch stage (instruction reads at PCF) and the memory stage (data loads/stores at ALUOutM/WriteDataM) of the pipelined core. It sequences one transaction at a time, with data given priority over fetch, and drives stall and valid signals back to the hazard unit. A watchdog counter turns a non-responding memory into an abort, which feeds prefetch/data-abort exception handling.

## Interface
Parameters:
- TIMEOUT, 255: cycles MemReq may stay high without MemAck before the access is aborted; legal range 1–65535.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high reset
- IReq  input  1  fetch wants instruction at IAdr
- IAdr  input  32  fetch word address (PCF)
- IFlush  input  1  pending or in-flight fetch is discarded (branch/exception redirect)
- DReq  input  1  memory stage wants an access
- DAdr  input  32  data address (ALUOutM)
- DWE  input  1  1 = store
- DWD  input  32  store data (already byte-replicated)
- DBE  input  4  store byte enables
- MemAck  input  1  memory has completed the current request
- MemRD  input  32  memory read data; valid when MemAck=1
- MemReq  output  1  request to memory, held until acknowledged
- MemAdr  output  32  registered address
- MemWE  output  1  registered write enable
- MemWD  output  32  registered write data
- MemBE  output  4  registered byte enables (4'b1111 for reads)
- InstrRd  output  32  fetched instruction (registered)
- IValid  output  1  one-cycle pulse: InstrRd is valid
- IAbort  output  1  one-cycle pulse with IValid: fetch timed out
- DataRd  output  32  load data (registered)
- DValid  output  1  one-cycle pulse: data access done
- DAbort  output  1  one-cycle pulse with DValid: data access timed out
- IStall  output  1  combinational: IReq & ~IValid
- DStall  output  1  combinational: DReq & ~DValid

## Operation
- States: IDLE, IACC, DACC, RESP.
- IDLE: if DReq, latch DAdr/DWE/DWD/DBE (MemBE=DBE if DWE else 4'hF) and go to DACC. Otherwise, if IReq & ~IFlush, latch IAdr (MemWE=0, MemBE=4'hF) and go to IACC. Otherwise stay in IDLE.
- Priority: when DReq and IReq are both high in IDLE, data wins. Fetch is served after the data response.
- IACC/DACC: MemReq=1 and all Mem* outputs stay stable. On MemAck: capture MemRD into InstrRd or DataRd, go to RESP.
- Watchdog: a 16-bit counter clears on entry to IACC/DACC and increments each cycle MemAck=0. If it reaches TIMEOUT-1 without an ack: go to RESP with the abort flag set and the captured data forced to 0. MemReq drops on the exit edge.
- RESP (one cycle): pulse IValid (plus IAbort if timed out) or DValid (plus DAbort if timed out), then go to IDLE. RESP exists so the requester sees IStall/DStall low and advances before the next arbitration, which prevents a stale address from being re-issued.
- IFlush:
  - In IDLE it blocks fetch acceptance.
  - Asserted any cycle during IACC, it sets a drop bit. The memory transaction still completes; RESP then asserts neither IValid nor IAbort.
  - The drop bit clears in IDLE.
- DStall/IStall are combinational from state and inputs. No path exists from MemAck to them, so there are no combinational loops to the hazard unit.
- Reset (asynchronous, any state, including mid-transaction): state=IDLE; MemReq=0, MemWE=0, MemAdr=0, MemWD=0, MemBE=0, InstrRd=0, DataRd=0; IValid=IAbort=DValid=DAbort=0; counter=0; drop bit=0. A memory ack arriving after reset release while in IDLE is ignored.

## Timing
- Cycle n: request seen in IDLE. Cycle n+1: MemReq=1. If MemAck is sampled at the end of cycle n+k (k≥1), cycle n+k+1 is RESP with the valid pulse. Minimum latency is 2 cycles from request to valid.
- Peak throughput: one access per 3 cycles with zero-wait memory.
- Back-to-back requests: the cycle after RESP is IDLE, where new arbitration occurs.
- Timeout: with no ack, MemReq is high for exactly TIMEOUT cycles, then RESP.
- Mem* outputs change only on the IDLE→ACC edge.
- MemAck outside IACC/DACC has no effect.

## Test plan
- Zero-wait fetch: IReq=1, IAdr=0x100, MemAck tied high, MemRD=0xE3A00001 -> MemReq high for 1 cycle, MemAdr=0x100, MemBE=4'hF; IValid pulses 2 cycles after IReq with InstrRd=0xE3A00001; IStall low only in that cycle.
- Simultaneous requests: IReq and DReq (DWE=1, DAdr=0x2000, DWD=0xAAAAAAAA, DBE=4'b0011) raised together, 2-cycle memory latency -> store issued first with MemBE=4'b0011; DValid pulses; fetch issued 1 cycle after the data RESP; IValid follows.
- Flush in flight: fetch to 0x104 issued, IFlush pulsed in the 2nd cycle of a 3-cycle ack -> memory transaction completes; no IValid; the next fetch (IAdr=0x200) proceeds normally.
- Timeout: TIMEOUT=4, DReq load, MemAck held low -> MemReq high for exactly 4 cycles; then DValid=1, DAbort=1, DataRd=0; state returns to IDLE.
- Reset mid-access: assert reset during DACC -> all outputs 0 immediately, without waiting for a clock edge. Release reset and pulse a spurious MemAck -> no DValid. A new fetch is served normally.
- Stall hold: during a 5-cycle ack wait, MemAdr/MemWD/MemBE stay constant while IAdr and DWD change; DStall=1 throughout until the DValid cycle.
